// File: rtl/accumulator_pkg.sv
// Shared encodings for the 16-bit accumulator CPU. The control FSM and the
// PC, memory, wires and ALU subsystems all import this package, so the
// select codes only need to be defined once.
package accumulator_pkg;

  localparam int OP_W    = 4;
  localparam int SRCB_W  = 3;
  localparam int ALUOP_W = 3;

  // Opcodes (IR[15:12]); 0xC-0xE are undefined
  localparam logic [OP_W-1:0] OP_LDA  = 4'h0;
  localparam logic [OP_W-1:0] OP_STA  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_W-1:0] OP_AND  = 4'h4;
  localparam logic [OP_W-1:0] OP_OR   = 4'h5;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h6;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h7;
  localparam logic [OP_W-1:0] OP_BNE  = 4'h8;
  localparam logic [OP_W-1:0] OP_J    = 4'h9;
  localparam logic [OP_W-1:0] OP_PUSH = 4'hA;
  localparam logic [OP_W-1:0] OP_POP  = 4'hB;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  // The read and write-back phases carry the operation in the state itself,
  // so the opcode only has to be looked at once, in DECODE.
  typedef enum logic [4:0] {
    S_FETCH, S_DECODE,
    S_RD_LDA, S_RD_ADD, S_RD_SUB, S_RD_AND, S_RD_OR,
    S_WB_LDA, S_WB_ADD, S_WB_SUB, S_WB_AND, S_WB_OR, S_WB_ADDI,
    S_MEM_WR, S_BR_EQ, S_BR_NE, S_JUMP,
    S_SP_DEC, S_PUSH_WR, S_POP_RD, S_POP_WB, S_POP_INC,
    S_HALT
  } state_e;

  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_ACC = 2'd1;
  localparam logic [1:0] SRCA_SP  = 2'd2;

  localparam logic [SRCB_W-1:0] SRCB_CONST2 = 3'd0;
  localparam logic [SRCB_W-1:0] SRCB_MDR    = 3'd1;
  localparam logic [SRCB_W-1:0] SRCB_SE     = 3'd2;
  localparam logic [SRCB_W-1:0] SRCB_ZE     = 3'd3;
  localparam logic [SRCB_W-1:0] SRCB_SL1    = 3'd4;
  localparam logic [SRCB_W-1:0] SRCB_CONST0 = 3'd5;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'd3;
  localparam logic [ALUOP_W-1:0] ALU_PASSB = 3'd4;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ZE     = 2'd1;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd2;

  localparam logic [1:0] ADDR_PC = 2'd0;
  localparam logic [1:0] ADDR_ZE = 2'd1;
  localparam logic [1:0] ADDR_SP = 2'd2;

endpackage

// File: rtl/accumulator_ctrl_decode.sv
// Combinational opcode decode for the control FSM.
//   opcode_i     : IR[15:12]
//   state_i      : current FSM state (selects the write-back ALU operation)
//   next_state_o : successor of DECODE for this opcode
//   illegal_o    : opcode is undefined
//   wb_alu_op_o  : ALUOp for the write-back state carrying the operation
module accumulator_ctrl_decode
  import accumulator_pkg::*;
(
  input  logic [OP_W-1:0]    opcode_i,
  input  state_e             state_i,
  output state_e             next_state_o,
  output logic               illegal_o,
  output logic [ALUOP_W-1:0] wb_alu_op_o
);

  always_comb begin
    next_state_o = S_HALT;
    illegal_o    = 1'b0;
    case (opcode_i)
      OP_LDA:  next_state_o = S_RD_LDA;
      OP_STA:  next_state_o = S_MEM_WR;
      OP_ADD:  next_state_o = S_RD_ADD;
      OP_SUB:  next_state_o = S_RD_SUB;
      OP_AND:  next_state_o = S_RD_AND;
      OP_OR:   next_state_o = S_RD_OR;
      OP_ADDI: next_state_o = S_WB_ADDI;
      OP_BEQ:  next_state_o = S_BR_EQ;
      OP_BNE:  next_state_o = S_BR_NE;
      OP_J:    next_state_o = S_JUMP;
      OP_PUSH: next_state_o = S_SP_DEC;
      OP_POP:  next_state_o = S_POP_RD;
      OP_HALT: next_state_o = S_HALT;
      default: illegal_o    = 1'b1;
    endcase
  end

  always_comb begin
    wb_alu_op_o = ALU_ADD;
    case (state_i)
      S_WB_LDA: wb_alu_op_o = ALU_PASSB;
      S_WB_SUB: wb_alu_op_o = ALU_SUB;
      S_WB_AND: wb_alu_op_o = ALU_AND;
      S_WB_OR:  wb_alu_op_o = ALU_OR;
      default:  wb_alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/accumulator_control.sv
// Multicycle Moore control FSM for the 16-bit accumulator CPU. Produces all
// datapath write enables and mux selects from the current state.
//   CLK, reset : clock, synchronous active-high reset
//   opcode     : IR[15:12], looked at only in DECODE
//   outputs    : PC, ACC/SP, ALU, memory and IR controls; halted, illegal
//
// state      | meaning
// FETCH      | read instruction, IR <= mem[PC], PC += 2
// DECODE     | aluOut <= PC + SL1 (branch target), dispatch on opcode
// RD_*       | read operand at ZE address for lda/add/sub/and/or
// WB_*       | ACC <= ACC op operand (MDR, or SE for addi)
// MEM_WR     | mem[ZE] <= ACC
// BR_EQ/NE   | ACC - 0 sets Zero, conditional PC <= aluOut
// JUMP       | PC <= ZE
// SP_DEC     | SP -= 2
// PUSH_WR    | mem[SP] <= ACC
// POP_RD     | read mem[SP]
// POP_WB     | ACC <= MDR
// POP_INC    | SP += 2
// HALT       | idle until reset
module accumulator_control
  import accumulator_pkg::*;
(
  input  logic               CLK,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  output logic               PCWrite,
  output logic               Branch,
  output logic               bneOrbeq,
  output logic [1:0]         PCSrc,
  output logic               AccWrite,
  output logic               SpWrite,
  output logic [1:0]         ALUSrcA,
  output logic [SRCB_W-1:0]  ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         AddrSrc,
  output logic               halted,
  output logic               illegal
);

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  state_e               dec_next;
  logic                 dec_illegal;
  logic [ALUOP_W-1:0]   wb_alu_op;
  logic pc_write, branch, acc_write, sp_write, mem_read, mem_write, ir_write;

  accumulator_ctrl_decode u_decode (
    .opcode_i     (opcode),
    .state_i      (state_q),
    .next_state_o (dec_next),
    .illegal_o    (dec_illegal),
    .wb_alu_op_o  (wb_alu_op)
  );

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        state_d   = dec_next;
        illegal_d = illegal_q | dec_illegal;
      end
      S_RD_LDA:  state_d = S_WB_LDA;
      S_RD_ADD:  state_d = S_WB_ADD;
      S_RD_SUB:  state_d = S_WB_SUB;
      S_RD_AND:  state_d = S_WB_AND;
      S_RD_OR:   state_d = S_WB_OR;
      S_SP_DEC:  state_d = S_PUSH_WR;
      S_POP_RD:  state_d = S_POP_WB;
      S_POP_WB:  state_d = S_POP_INC;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore outputs; anything not listed for a state stays 0, which also
  // covers unused encodings.
  always_comb begin
    pc_write  = 1'b0;
    branch    = 1'b0;
    acc_write = 1'b0;
    sp_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    bneOrbeq  = 1'b0;
    PCSrc     = PCSRC_ALU;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_CONST2;
    ALUOp     = ALU_ADD;
    AddrSrc   = ADDR_PC;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: ALUSrcB = SRCB_SL1;
      S_RD_LDA, S_RD_ADD, S_RD_SUB, S_RD_AND, S_RD_OR: begin
        mem_read = 1'b1;
        AddrSrc  = ADDR_ZE;
      end
      S_WB_LDA, S_WB_ADD, S_WB_SUB, S_WB_AND, S_WB_OR, S_WB_ADDI: begin
        acc_write = 1'b1;
        ALUSrcA   = SRCA_ACC;
        ALUSrcB   = (state_q == S_WB_ADDI) ? SRCB_SE : SRCB_MDR;
        ALUOp     = wb_alu_op;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        AddrSrc   = ADDR_ZE;
      end
      S_BR_EQ, S_BR_NE: begin
        ALUSrcA  = SRCA_ACC;
        ALUSrcB  = SRCB_CONST0;
        ALUOp    = ALU_SUB;
        branch   = 1'b1;
        bneOrbeq = (state_q == S_BR_NE);
        PCSrc    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSrc    = PCSRC_ZE;
      end
      S_SP_DEC: begin
        ALUSrcA  = SRCA_SP;
        ALUOp    = ALU_SUB;
        sp_write = 1'b1;
      end
      S_PUSH_WR: begin
        mem_write = 1'b1;
        AddrSrc   = ADDR_SP;
      end
      S_POP_RD: begin
        mem_read = 1'b1;
        AddrSrc  = ADDR_SP;
      end
      S_POP_WB: begin
        acc_write = 1'b1;
        ALUSrcB   = SRCB_MDR;
        ALUOp     = ALU_PASSB;
      end
      S_POP_INC: begin
        ALUSrcA  = SRCA_SP;
        sp_write = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Reset gates the strobes combinationally so nothing is written while the
  // state register is being forced back to FETCH.
  assign PCWrite  = pc_write  & ~reset;
  assign Branch   = branch    & ~reset;
  assign AccWrite = acc_write & ~reset;
  assign SpWrite  = sp_write  & ~reset;
  assign MemRead  = mem_read  & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_accumulator_control.sv
module tb_accumulator_control;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       PCWrite, Branch, bneOrbeq, AccWrite, SpWrite;
  logic       MemRead, MemWrite, IRWrite, halted, illegal;
  logic [1:0] PCSrc, ALUSrcA, AddrSrc;
  logic [2:0] ALUSrcB, ALUOp;

  accumulator_control dut (
    .CLK(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .Branch(Branch), .bneOrbeq(bneOrbeq), .PCSrc(PCSrc),
    .AccWrite(AccWrite), .SpWrite(SpWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AddrSrc(AddrSrc), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side state names (read phases share one output pattern)
  localparam int T_FETCH = 0, T_DECODE = 1, T_MEM_RD = 2, T_WB_LDA = 3,
                 T_WB_ADD = 4, T_WB_SUB = 5, T_WB_AND = 6, T_WB_OR = 7,
                 T_WB_ADDI = 8, T_MEM_WR = 9, T_BR_EQ = 10, T_BR_NE = 11,
                 T_JUMP = 12, T_SP_DEC = 13, T_PUSH_WR = 14, T_POP_RD = 15,
                 T_POP_WB = 16, T_POP_INC = 17, T_HALT = 18;

  // {PCWrite,Branch,AccWrite,SpWrite,MemRead,MemWrite,IRWrite,halted,illegal,
  //  bneOrbeq,PCSrc,ALUSrcA,ALUSrcB,ALUOp,AddrSrc}
  localparam logic [21:0] MASK_ALL = 22'h3FFFFF;
  localparam logic [21:0] MASK_RST = 22'h3FE000;
  localparam logic [21:0] ENABLES  = 22'h3F8000;

  logic [21:0] act;
  assign act = {PCWrite, Branch, AccWrite, SpWrite, MemRead, MemWrite, IRWrite,
                halted, illegal, bneOrbeq, PCSrc, ALUSrcA, ALUSrcB, ALUOp, AddrSrc};

  logic [21:0] exp_q[$];
  logic [21:0] mask_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [21:0] pk(
    input logic pcw, input logic br, input logic accw, input logic spw,
    input logic mr, input logic mw, input logic irw, input logic hlt,
    input logic bne, input logic [1:0] pcs, input logic [1:0] sa,
    input logic [2:0] sb, input logic [2:0] op, input logic [1:0] ad);
    return {pcw, br, accw, spw, mr, mw, irw, hlt, 1'b0, bne, pcs, sa, sb, op, ad};
  endfunction

  // Hand-written table of expected outputs per state
  function automatic logic [21:0] exp_vec(input int st, input logic ill, input logic rst);
    logic [21:0] v;
    case (st)
      //                pcw br aw sw mr mw ir hl bne pcs sa  sb  op  ad
      T_FETCH:   v = pk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      T_DECODE:  v = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
      T_MEM_RD:  v = pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      T_WB_LDA:  v = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0);
      T_WB_ADD:  v = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      T_WB_SUB:  v = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      T_WB_AND:  v = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
      T_WB_OR:   v = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0);
      T_WB_ADDI: v = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
      T_MEM_WR:  v = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      T_BR_EQ:   v = pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 5, 1, 0);
      T_BR_NE:   v = pk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 5, 1, 0);
      T_JUMP:    v = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      T_SP_DEC:  v = pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
      T_PUSH_WR: v = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2);
      T_POP_RD:  v = pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      T_POP_WB:  v = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
      T_POP_INC: v = pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
      default:   v = pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endcase
    v[13] = ill;
    if (rst) v = v & ~ENABLES & MASK_RST;
    return v;
  endfunction

  // Advance one cycle, drive inputs for the new cycle and queue what the DUT
  // must present during it.
  task automatic step(input logic rst, input logic [3:0] op, input int st,
                      input logic ill, input string tag);
    @(posedge clk);
    #1;
    reset  = rst;
    opcode = op;
    exp_q.push_back(exp_vec(st, ill, rst));
    mask_q.push_back(rst ? MASK_RST : MASK_ALL);
    tag_q.push_back(tag);
  endtask

  // Monitor: compares on the falling edge, decoupled from stimulus
  initial begin
    logic [21:0] e, m;
    string       t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        if ((act & m) !== e) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h (mask %h)", t, act & m, e, m);
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    opcode = 4'h0;
    // reset held three cycles, then the first live cycle is FETCH
    step(1, 4'h0, T_FETCH, 0, "reset_0");
    step(1, 4'h0, T_FETCH, 0, "reset_1");
    step(1, 4'h0, T_FETCH, 0, "reset_2");
    // add, with opcode noise outside DECODE
    step(0, 4'hC, T_FETCH,   0, "add_fetch");
    step(0, 4'h2, T_DECODE,  0, "add_decode");
    step(0, 4'hF, T_MEM_RD,  0, "add_memrd");
    step(0, 4'h9, T_WB_ADD,  0, "add_wb");
    // sta
    step(0, 4'hD, T_FETCH,   0, "sta_fetch");
    step(0, 4'h1, T_DECODE,  0, "sta_decode");
    step(0, 4'hA, T_MEM_WR,  0, "sta_memwr");
    // lda
    step(0, 4'h1, T_FETCH,   0, "lda_fetch");
    step(0, 4'h0, T_DECODE,  0, "lda_decode");
    step(0, 4'hB, T_MEM_RD,  0, "lda_memrd");
    step(0, 4'h7, T_WB_LDA,  0, "lda_wb");
    // addi
    step(0, 4'h0, T_FETCH,   0, "addi_fetch");
    step(0, 4'h6, T_DECODE,  0, "addi_decode");
    step(0, 4'hE, T_WB_ADDI, 0, "addi_wb");
    // sub / and / or
    step(0, 4'h6, T_FETCH,   0, "sub_fetch");
    step(0, 4'h3, T_DECODE,  0, "sub_decode");
    step(0, 4'h0, T_MEM_RD,  0, "sub_memrd");
    step(0, 4'h2, T_WB_SUB,  0, "sub_wb");
    step(0, 4'h3, T_FETCH,   0, "and_fetch");
    step(0, 4'h4, T_DECODE,  0, "and_decode");
    step(0, 4'h5, T_MEM_RD,  0, "and_memrd");
    step(0, 4'h3, T_WB_AND,  0, "and_wb");
    step(0, 4'h4, T_FETCH,   0, "or_fetch");
    step(0, 4'h5, T_DECODE,  0, "or_decode");
    step(0, 4'h4, T_MEM_RD,  0, "or_memrd");
    step(0, 4'h0, T_WB_OR,   0, "or_wb");
    // bne, beq, j
    step(0, 4'h2, T_FETCH,   0, "bne_fetch");
    step(0, 4'h8, T_DECODE,  0, "bne_decode");
    step(0, 4'h7, T_BR_NE,   0, "bne_branch");
    step(0, 4'h8, T_FETCH,   0, "beq_fetch");
    step(0, 4'h7, T_DECODE,  0, "beq_decode");
    step(0, 4'h8, T_BR_EQ,   0, "beq_branch");
    step(0, 4'h0, T_FETCH,   0, "j_fetch");
    step(0, 4'h9, T_DECODE,  0, "j_decode");
    step(0, 4'hF, T_JUMP,    0, "j_jump");
    // push then pop
    step(0, 4'h0, T_FETCH,   0, "push_fetch");
    step(0, 4'hA, T_DECODE,  0, "push_decode");
    step(0, 4'hB, T_SP_DEC,  0, "push_spdec");
    step(0, 4'hF, T_PUSH_WR, 0, "push_wr");
    step(0, 4'h1, T_FETCH,   0, "pop_fetch");
    step(0, 4'hB, T_DECODE,  0, "pop_decode");
    step(0, 4'hA, T_POP_RD,  0, "pop_rd");
    step(0, 4'hD, T_POP_WB,  0, "pop_wb");
    step(0, 4'h3, T_POP_INC, 0, "pop_inc");
    // reset asserted during ALU_WB suppresses AccWrite, FETCH follows
    step(0, 4'h0, T_FETCH,   0, "rstwb_fetch");
    step(0, 4'h2, T_DECODE,  0, "rstwb_decode");
    step(0, 4'h2, T_MEM_RD,  0, "rstwb_memrd");
    step(1, 4'h2, T_WB_ADD,  0, "rstwb_gated");
    step(0, 4'h2, T_FETCH,   0, "rstwb_refetch");
    // halt opcode: halted without illegal, then reset out
    step(0, 4'hF, T_DECODE,  0, "halt_decode");
    step(0, 4'h2, T_HALT,    0, "halt_0");
    step(0, 4'h0, T_HALT,    0, "halt_1");
    step(1, 4'h0, T_HALT,    0, "halt_rst");
    step(0, 4'h0, T_FETCH,   0, "halt_refetch");
    // undefined opcode D: sticky illegal for 20 cycles
    step(0, 4'hD, T_DECODE,  0, "illD_decode");
    for (int i = 0; i < 20; i++)
      step(0, 4'(i), T_HALT, 1, $sformatf("illD_halt_%0d", i));
    step(1, 4'h0, T_HALT,    1, "illD_rst");
    step(0, 4'h0, T_FETCH,   0, "illD_refetch");
    // undefined opcode E
    step(0, 4'hE, T_DECODE,  0, "illE_decode");
    step(0, 4'h2, T_HALT,    1, "illE_halt");
    step(1, 4'h2, T_HALT,    1, "illE_rst");
    step(0, 4'h2, T_FETCH,   0, "illE_refetch");
    step(0, 4'hC, T_DECODE,  0, "illC_decode");
    step(0, 4'h0, T_HALT,    1, "illC_halt");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
